// File: rtl/gb_pkg.sv
// Shared Game Boy definitions for the console blocks.
// Constant-only package; no logic, no latency, no flow control.
package gb_pkg;
    localparam int         OAM_LEN   = 160;
    localparam logic [6:0] IO_OAMDMA = 7'h46;

    typedef enum logic [1:0] {DMA_IDLE, DMA_SETUP, DMA_ACTIVE} oamdma_state_t;
endpackage

// File: rtl/oamdma_controller.sv
// OAM DMA sequencer: FF46 register, source/OAM counters, start delay and restart.
// First byte two M-cycles after the FF46 write, one byte per M-strobe; hdma freezes progress.
module oamdma_controller
    import gb_pkg::*;
#(
    parameter int LEN         = OAM_LEN,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [1:0]  t,
    input  logic        hdma,
    input  logic        write,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        oamdma,
    output logic [15:0] oamdma_src_addr,
    output logic [7:0]  oam_dst_addr,
    output logic        oamdma_write
);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);
    localparam logic [7:0] DELAY_LD = 8'(START_DELAY);

    oamdma_state_t r_state, w_state_nxt;
    logic [7:0]    r_rdata, r_src_hi, r_cur_hi, r_idx, r_delay;
    logic          r_pending, r_xfer, r_oamdma;
    logic [7:0]    w_cur_hi_nxt, w_idx_nxt, w_delay_nxt, w_src_hi;
    logic          w_pending_nxt, w_xfer_nxt, w_oamdma_nxt;
    logic          w_wr, w_mstrobe, w_pend;

    assign w_wr      = write & cpu_en;
    assign w_mstrobe = cpu_en && (t == 2'd3) && !hdma;
    assign w_pend    = r_pending | w_wr;
    // Echo RAM E000-FFFF mirrors C000-DFFF.
    assign w_src_hi  = (wdata >= 8'hE0) ? wdata - 8'h20 : wdata;

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_hi_nxt  = r_cur_hi;
        w_idx_nxt     = r_idx;
        w_delay_nxt   = w_wr ? DELAY_LD : r_delay;
        w_pending_nxt = w_pend;
        w_xfer_nxt    = r_xfer;
        if (w_mstrobe) begin
            // The running transfer keeps copying while a restart counts down its delay.
            if (r_xfer) begin
                if (r_idx == LAST_IDX) w_xfer_nxt = 1'b0;
                else                   w_idx_nxt  = r_idx + 8'd1;
            end
            case (r_state)
                DMA_IDLE: begin
                    if (w_pend) begin
                        w_state_nxt   = DMA_SETUP;
                        w_pending_nxt = 1'b0;
                    end
                end
                DMA_SETUP: begin
                    if (r_delay <= 8'd1) begin
                        w_state_nxt  = DMA_ACTIVE;
                        w_cur_hi_nxt = r_src_hi;
                        w_idx_nxt    = 8'd0;
                        w_xfer_nxt   = 1'b1;
                    end
                    if (!w_wr) w_delay_nxt = (r_delay == 8'd0) ? 8'd0 : r_delay - 8'd1;
                end
                DMA_ACTIVE: begin
                    if (w_pend) begin
                        w_state_nxt   = DMA_SETUP;
                        w_pending_nxt = 1'b0;
                    end else if (!w_xfer_nxt) begin
                        w_state_nxt = DMA_IDLE;
                    end
                end
                default: w_state_nxt = DMA_IDLE;
            endcase
        end
        // A restart from a busy bus keeps the takeover flag up through its setup.
        w_oamdma_nxt = w_xfer_nxt | ((w_state_nxt == DMA_SETUP) & r_oamdma);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= DMA_IDLE;
            r_rdata   <= 8'hFF;
            r_src_hi  <= 8'h00;
            r_cur_hi  <= 8'h00;
            r_idx     <= 8'h00;
            r_delay   <= 8'h00;
            r_pending <= 1'b0;
            r_xfer    <= 1'b0;
            r_oamdma  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_hi  <= w_cur_hi_nxt;
            r_idx     <= w_idx_nxt;
            r_delay   <= w_delay_nxt;
            r_pending <= w_pending_nxt;
            r_xfer    <= w_xfer_nxt;
            r_oamdma  <= w_oamdma_nxt;
            if (w_wr) begin
                r_rdata  <= wdata;
                r_src_hi <= w_src_hi;
            end
        end
    end

    assign rdata           = r_rdata;
    assign oamdma          = r_oamdma;
    assign oamdma_src_addr = {r_cur_hi, r_idx};
    assign oam_dst_addr    = r_idx;
    assign oamdma_write    = r_xfer & w_mstrobe & ~reset;
endmodule

// File: tb/tb_oamdma_controller.sv
// Bench for oamdma_controller: table vectors, hand-written corner sequences, random traffic.
// Reference model counts effective M-strobes and schedules each transfer from its write point.
module tb_oamdma_controller;
    localparam int LEN = 160;

    logic        clk, reset, cpu_en, hdma, write;
    logic [1:0]  t;
    logic [7:0]  wdata, rdata, oam_dst_addr;
    logic        oamdma, oamdma_write;
    logic [15:0] oamdma_src_addr;

    int total = 0;
    int bad   = 0;

    oamdma_controller #(.LEN(LEN), .START_DELAY(1)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .t(t), .hdma(hdma),
        .write(write), .wdata(wdata), .rdata(rdata), .oamdma(oamdma),
        .oamdma_src_addr(oamdma_src_addr), .oam_dst_addr(oam_dst_addr),
        .oamdma_write(oamdma_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: effective strobe count, running copy, pending start.
    int         m_cnt, m_go;
    bit         m_act, m_sv, m_dma;
    logic [7:0] m_hi, m_i, m_newhi, m_ff46;
    logic [1:0] tc;

    // Observations of the DUT for the directed checks.
    logic [15:0] q_src[$];
    logic [7:0]  q_dst[$];
    int          dma_m, nstrobe, first_hi;

    typedef struct {
        logic [7:0]  wd;
        bit          half;
        logic [15:0] src0;
        logic [15:0] src_last;
    } vec_t;
    vec_t vt[6];

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_go = 0; m_act = 0; m_sv = 0; m_dma = 0;
        m_hi = 8'h00; m_i = 8'h00; m_newhi = 8'h00; m_ff46 = 8'hFF;
    endfunction

    function automatic void clr();
        q_src.delete(); q_dst.delete();
        dma_m = 0; nstrobe = 0; first_hi = -1;
    endfunction

    task automatic step(input bit en, input bit h, input bit w, input logic [7:0] wd, input bit rst);
        bit strobe, eff;
        int pre;
        @(negedge clk);
        reset = rst; cpu_en = en; t = tc; hdma = h; write = w; wdata = wd;
        #1;
        strobe = en && (tc == 2'd3);
        eff    = strobe && !h;
        if (strobe) begin
            nstrobe++;
            if (oamdma) begin
                dma_m++;
                if (first_hi < 0) first_hi = nstrobe;
            end
        end
        if (oamdma_write) begin
            q_src.push_back(oamdma_src_addr);
            q_dst.push_back(oam_dst_addr);
        end
        if (!rst) begin
            chk("rdata", 32'(rdata), 32'(m_ff46));
            chk("oamdma", 32'(oamdma), 32'(m_dma));
            if (m_act) begin
                chk("src_addr", 32'(oamdma_src_addr), 32'({m_hi, m_i}));
                chk("dst_addr", 32'(oam_dst_addr), 32'(m_i));
            end
            chk("write_pulse", 32'(oamdma_write), 32'(eff && m_act));
            pre = m_cnt;
            if (eff) begin
                if (m_act) begin
                    if (32'(m_i) == LEN - 1) m_act = 0;
                    else                     m_i = m_i + 8'd1;
                end
                m_cnt++;
                if (m_sv && m_cnt == m_go) begin
                    m_hi = m_newhi; m_i = 8'h00; m_act = 1; m_sv = 0;
                end
                m_dma = m_act || (m_sv && m_dma);
            end
            if (w && en) begin
                m_ff46  = wd;
                m_newhi = (wd >= 8'hE0) ? wd - 8'h20 : wd;
                m_go    = pre + 2;
                m_sv    = 1;
            end
        end else begin
            model_reset();
        end
        if (en) tc = tc + 2'd1;
    endtask

    // One M-cycle; optional FF46 write on its first enabled clk.
    task automatic mcyc(input bit h, input bit w, input logic [7:0] wd, input bit half);
        bit done, wp, en;
        done = 0; wp = w;
        while (!done) begin
            en   = half ? 1'($urandom_range(0, 1)) : 1'b1;
            done = en && (tc == 2'd3);
            step(en, h, wp && en, wd, 1'b0);
            if (en) wp = 0;
        end
    endtask

    task automatic run_until(input int npulse, input int bound);
        int k;
        k = 0;
        while (q_src.size() < npulse && k < bound) begin
            mcyc(1'b0, 1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("reach_pulses", q_src.size(), npulse);
    endtask

    initial begin
        int n90;
        bit en, h, w;
        reset = 1; cpu_en = 0; t = 0; hdma = 0; write = 0; wdata = 0; tc = 0;
        model_reset();
        clr();
        vt[0] = '{8'hC1, 1'b0, 16'hC100, 16'hC19F};
        vt[1] = '{8'hF3, 1'b0, 16'hD300, 16'hD39F};
        vt[2] = '{8'hE0, 1'b0, 16'hC000, 16'hC09F};
        vt[3] = '{8'hDF, 1'b1, 16'hDF00, 16'hDF9F};
        vt[4] = '{8'h00, 1'b1, 16'h0000, 16'h009F};
        vt[5] = '{8'hFF, 1'b0, 16'hDF00, 16'hDF9F};

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("rst_oamdma", 32'(oamdma), 0);
        chk("rst_write", 32'(oamdma_write), 0);
        chk("rst_src", 32'(oamdma_src_addr), 0);
        chk("rst_dst", 32'(oam_dst_addr), 0);
        chk("rst_rdata", 32'(rdata), 32'hFF);

        for (int v = 0; v < 6; v++) begin
            clr();
            mcyc(1'b0, 1'b1, vt[v].wd, vt[v].half);
            for (int m = 0; m < 170; m++) mcyc(1'b0, 1'b0, 8'h00, vt[v].half);
            chk("tv_npulse", q_src.size(), LEN);
            if (q_src.size() == LEN) begin
                chk("tv_src_first", 32'(q_src[0]), 32'(vt[v].src0));
                chk("tv_src_last", 32'(q_src[LEN-1]), 32'(vt[v].src_last));
                chk("tv_dst_first", 32'(q_dst[0]), 0);
                chk("tv_dst_last", 32'(q_dst[LEN-1]), LEN - 1);
            end
            chk("tv_dma_mcycles", dma_m, LEN);
            chk("tv_rise_mcycle", first_hi, 3);
            chk("tv_rdata", 32'(rdata), 32'(vt[v].wd));
        end

        // Restart at byte 50: two more old bytes, then the new source from OAM 0.
        clr();
        mcyc(1'b0, 1'b1, 8'h80, 1'b0);
        run_until(51, 200);
        mcyc(1'b0, 1'b1, 8'h90, 1'b0);
        for (int m = 0; m < 170; m++) mcyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rs_npulse", q_src.size(), 53 + LEN);
        if (q_src.size() == 53 + LEN) begin
            chk("rs_byte51", 32'(q_src[51]), 32'h8033);
            chk("rs_byte52", 32'(q_src[52]), 32'h8034);
            chk("rs_new_src", 32'(q_src[53]), 32'h9000);
            chk("rs_new_dst", 32'(q_dst[53]), 0);
        end
        n90 = 0;
        foreach (q_src[k]) if (q_src[k][15:8] == 8'h90) n90++;
        chk("rs_n90", n90, LEN);
        chk("rs_dma_mcycles", dma_m, 53 + LEN);

        // hdma hold for 20 M-cycles at byte 10.
        clr();
        mcyc(1'b0, 1'b1, 8'hC2, 1'b0);
        run_until(10, 100);
        for (int m = 0; m < 20; m++) mcyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("hd_no_pulses", q_src.size(), 10);
        chk("hd_idx_held", 32'(oam_dst_addr), 10);
        chk("hd_oamdma_held", 32'(oamdma), 1);
        for (int m = 0; m < 190; m++) mcyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("hd_npulse", q_src.size(), LEN);
        if (q_src.size() == LEN) chk("hd_resume_src", 32'(q_src[10]), 32'hC20A);
        chk("hd_dma_mcycles", dma_m, LEN + 20);

        // Write during the final byte's M-cycle.
        clr();
        mcyc(1'b0, 1'b1, 8'hA0, 1'b0);
        run_until(LEN - 1, 200);
        mcyc(1'b0, 1'b1, 8'hB0, 1'b0);
        for (int m = 0; m < 170; m++) mcyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fb_npulse", q_src.size(), 2 * LEN);
        if (q_src.size() == 2 * LEN) begin
            chk("fb_old_last", 32'(q_src[LEN-1]), 32'hA09F);
            chk("fb_new_first", 32'(q_src[LEN]), 32'hB000);
            chk("fb_new_last", 32'(q_src[2*LEN-1]), 32'hB09F);
        end
        chk("fb_dma_mcycles", dma_m, 2 * LEN + 1);

        // Reset at byte 80.
        clr();
        mcyc(1'b0, 1'b1, 8'h55, 1'b0);
        run_until(80, 200);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("mr_oamdma", 32'(oamdma), 0);
        chk("mr_rdata", 32'(rdata), 32'hFF);
        chk("mr_src", 32'(oamdma_src_addr), 0);
        for (int m = 0; m < 50; m++) mcyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mr_no_pulses", q_src.size(), 80);

        // Random traffic against the model.
        h = 0;
        for (int c = 0; c < 6000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) h = !h;
            w = en && !m_sv && ($urandom_range(0, 39) == 0);
            step(en, h, w, 8'($urandom_range(0, 255)), ($urandom_range(0, 2499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
